// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/LS memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Cycle counter with synchronous clear and a terminal-count flag; shared by the
// response-wait and drain phases of the arbiter.
module arb_timeout_cnt #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 254
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TERM_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: one
// outstanding transaction, response routed to its owner, timeout-bounded.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_err,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [DATA_W/8-1:0]   ls_be,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  ls_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_err,
    output logic                  busy
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e       state_q, state_d;
    arb_owner_e       owner_q, owner_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             tmo_clear, tmo_tc;
    logic             idle_arb, force_if, win_ls, granted, resp_fire;
    logic [DATA_W-1:0] resp_rdata;
    logic             resp_err;

    // Arbitration is suppressed while reset is held so no grant is lost.
    assign idle_arb = reset && (state_q == IDLE);
    assign force_if = if_req && (starve_q == STARVE_LIM);
    assign win_ls   = ls_req && !force_if;

    assign mem_req   = idle_arb && (if_req || ls_req);
    assign mem_we    = win_ls && ls_we;
    assign mem_be    = win_ls ? ls_be : '1;
    assign mem_addr  = win_ls ? ls_addr : if_addr;
    assign mem_wdata = win_ls ? ls_wdata : '0;

    assign granted = mem_req && mem_gnt;
    assign ls_gnt  = granted && win_ls;
    assign if_gnt  = granted && !win_ls;

    // A response on the terminal cycle wins over the synthesized timeout error.
    assign resp_fire  = reset && (state_q == WAIT) && (mem_rvalid || tmo_tc);
    assign resp_rdata = mem_rvalid ? mem_rdata : '0;
    assign resp_err   = mem_rvalid ? mem_err : 1'b1;

    assign if_rvalid = resp_fire && (owner_q == OWN_IF);
    assign ls_rvalid = resp_fire && (owner_q == OWN_LS);
    assign if_rdata  = if_rvalid ? resp_rdata : '0;
    assign ls_rdata  = ls_rvalid ? resp_rdata : '0;
    assign if_err    = if_rvalid && resp_err;
    assign ls_err    = ls_rvalid && resp_err;

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        tmo_clear = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_clear = 1'b1;
                if (granted) begin
                    state_d = WAIT;
                    owner_d = win_ls ? OWN_LS : OWN_IF;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d   = IDLE;
                    tmo_clear = 1'b1;
                end else if (tmo_tc) begin
                    state_d   = DRAIN;
                    tmo_clear = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_rvalid || tmo_tc) begin
                    state_d   = IDLE;
                    tmo_clear = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                tmo_clear = 1'b1;
            end
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (ls_gnt && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    arb_timeout_cnt #(
        .WIDTH    (TMO_W),
        .TERMINAL (TIMEOUT - 1)
    ) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmo_clear),
        .enable (state_q != IDLE),
        .tc     (tmo_tc)
    );

endmodule
